// File: rtl/qdr_traffic_checker.sv
// Write/read-back traffic checker for the QDR controller user port: writes a patterned run,
// reads it back in order, and reports mismatches, first failing address and read timeouts.
module qdr_traffic_checker #(
  parameter int unsigned RAM_WIDTH       = 36,
  parameter int unsigned ADDR_BITS       = 18,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned TIMEOUT         = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [ADDR_BITS-1:0]   base_addr,
  input  logic [ADDR_BITS-1:0]   count,
  input  logic [31:0]            seed,
  input  logic                   loop_en,
  input  logic                   stop,
  output logic                   wr_en,
  output logic [ADDR_BITS-1:0]   wr_addr,
  output logic [4*RAM_WIDTH-1:0] wr_data,
  output logic                   rd_en,
  output logic [ADDR_BITS-1:0]   rd_addr,
  input  logic                   rd_valid,
  input  logic [4*RAM_WIDTH-1:0] rd_data,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            err_count,
  output logic [ADDR_BITS-1:0]   first_err_addr,
  output logic                   timeout,
  output logic [15:0]            pass_count
);

  localparam int unsigned DATA_W = 4 * RAM_WIDTH;
  localparam int unsigned WW     = $clog2(DATA_W);
  localparam int unsigned OW     = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned TW     = $clog2(TIMEOUT) + 1;
  localparam int unsigned CW     = ADDR_BITS + 1;
  localparam int unsigned REPS   = DATA_W / 32 + 1;

  localparam logic [OW-1:0] OutMax  = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] ToLast  = TW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WalkEnd = WW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StEnd} state_e;

  function automatic logic [RAM_WIDTH-1:0] addr_lane(input logic [ADDR_BITS-1:0] a,
                                                     input logic [1:0] k);
    return RAM_WIDTH'({a, k});
  endfunction

  function automatic logic [DATA_W-1:0] gen_word(input logic [1:0] m,
                                                 input logic [ADDR_BITS-1:0] a,
                                                 input logic [31:0] l,
                                                 input logic [WW-1:0] w);
    logic [DATA_W-1:0] word;
    word = {addr_lane(a, 2'd3), addr_lane(a, 2'd2), addr_lane(a, 2'd1), addr_lane(a, 2'd0)};
    unique case (m)
      2'd1:    word = DATA_W'({REPS{l}});
      2'd2:    word = {{(DATA_W-1){1'b0}}, 1'b1} << w;
      2'd3:    word = ~word;
      default: word = word;
    endcase
    return word;
  endfunction

  // Galois form of x^32 + x^22 + x^2 + x + 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [WW-1:0] walk_step(input logic [WW-1:0] w);
    return (w == WalkEnd) ? '0 : w + 1'b1;
  endfunction

  state_e                state_q, state_d;
  logic [1:0]            mode_q;
  logic [ADDR_BITS-1:0]  base_q;
  logic [CW-1:0]         count_q;
  logic [31:0]           seed_q;
  logic                  stop_q;
  logic [CW-1:0]         wr_left_q, rd_left_q;
  logic [ADDR_BITS-1:0]  wr_addr_q, rd_addr_q, exp_addr_q;
  logic [31:0]           wr_lfsr_q, exp_lfsr_q;
  logic [WW-1:0]         wr_walk_q, exp_walk_q;
  logic [OW-1:0]         outst_q;
  logic [TW-1:0]         to_cnt_q;
  logic                  miss_q;
  logic [ADDR_BITS-1:0]  miss_addr_q;
  logic [15:0]           err_q, pass_q;
  logic [ADDR_BITS-1:0]  first_err_q;
  logic                  timeout_q;

  logic                  accept, load, ret_ok, spurious, to_run, to_hit;
  logic [ADDR_BITS-1:0]  ld_base;
  logic [CW-1:0]         ld_count;
  logic [31:0]           ld_seed;
  logic [DATA_W-1:0]     exp_word;

  assign accept   = (state_q == StIdle) && start;
  assign ret_ok   = rd_valid && (outst_q != '0);
  assign spurious = rd_valid && (outst_q == '0);
  assign to_run   = (outst_q != '0) && !rd_valid;
  assign to_hit   = to_run && (to_cnt_q == ToLast);
  assign exp_word = gen_word(mode_q, exp_addr_q, exp_lfsr_q, exp_walk_q);

  assign wr_en   = (state_q == StWrite);
  assign wr_addr = wr_en ? wr_addr_q : '0;
  assign wr_data = wr_en ? gen_word(mode_q, wr_addr_q, wr_lfsr_q, wr_walk_q) : '0;
  assign rd_en   = (state_q == StRead) && (outst_q != OutMax);
  assign rd_addr = rd_en ? rd_addr_q : '0;

  assign busy           = (state_q != StIdle);
  assign err_count      = err_q;
  assign first_err_addr = first_err_q;
  assign timeout        = timeout_q;
  assign pass_count     = pass_q;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle:  if (start) state_d = StWrite;
      StWrite: if (wr_left_q == CW'(1)) state_d = StRead;
      StRead:  if (rd_en && (rd_left_q == CW'(1))) state_d = StDrain;
      StDrain: if (outst_q == '0) state_d = StEnd;
      StEnd: begin
        if (loop_en && !stop_q && !stop) begin
          state_d = StWrite;
        end else begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (to_hit) begin
      state_d = StIdle;
      done    = 1'b1;
    end
  end

  // Both generators restart from the run parameters on a new run and on every loop pass.
  always_comb begin
    load     = accept || ((state_q == StEnd) && (state_d == StWrite));
    ld_base  = accept ? base_addr : base_q;
    ld_count = count_q;
    ld_seed  = seed_q;
    if (accept) begin
      ld_count = (count == '0) ? {1'b1, {ADDR_BITS{1'b0}}} : {1'b0, count};
      ld_seed  = (seed == 32'h0) ? 32'h1 : seed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 2'd0;
      base_q  <= '0;
      count_q <= '0;
      seed_q  <= 32'h0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q  <= mode;
        base_q  <= base_addr;
        count_q <= ld_count;
        seed_q  <= ld_seed;
        stop_q  <= 1'b0;
      end else if (stop && busy) begin
        stop_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_left_q  <= '0;
      wr_addr_q  <= '0;
      wr_lfsr_q  <= 32'h0;
      wr_walk_q  <= '0;
      rd_left_q  <= '0;
      rd_addr_q  <= '0;
      exp_addr_q <= '0;
      exp_lfsr_q <= 32'h0;
      exp_walk_q <= '0;
    end else if (load) begin
      wr_left_q  <= ld_count;
      wr_addr_q  <= ld_base;
      wr_lfsr_q  <= ld_seed;
      wr_walk_q  <= '0;
      rd_left_q  <= ld_count;
      rd_addr_q  <= ld_base;
      exp_addr_q <= ld_base;
      exp_lfsr_q <= ld_seed;
      exp_walk_q <= '0;
    end else begin
      if (wr_en) begin
        wr_left_q <= wr_left_q - 1'b1;
        wr_addr_q <= wr_addr_q + 1'b1;
        wr_lfsr_q <= lfsr_step(wr_lfsr_q);
        wr_walk_q <= walk_step(wr_walk_q);
      end
      if (rd_en) begin
        rd_left_q <= rd_left_q - 1'b1;
        rd_addr_q <= rd_addr_q + 1'b1;
      end
      if (ret_ok) begin
        exp_addr_q <= exp_addr_q + 1'b1;
        exp_lfsr_q <= lfsr_step(exp_lfsr_q);
        exp_walk_q <= walk_step(exp_walk_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_q  <= '0;
      to_cnt_q <= '0;
    end else begin
      if (to_hit) begin
        outst_q <= '0;
      end else begin
        unique case ({rd_en, ret_ok})
          2'b10:   outst_q <= outst_q + 1'b1;
          2'b01:   outst_q <= outst_q - 1'b1;
          default: outst_q <= outst_q;
        endcase
      end
      to_cnt_q <= (to_run && !to_hit) ? to_cnt_q + 1'b1 : '0;
    end
  end

  // Mismatch is registered first; counters update one cycle after the return.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_q      <= 1'b0;
      miss_addr_q <= '0;
      err_q       <= 16'h0;
      first_err_q <= '0;
      timeout_q   <= 1'b0;
      pass_q      <= 16'h0;
    end else begin
      miss_q      <= !accept && (spurious || (ret_ok && (rd_data != exp_word)));
      miss_addr_q <= spurious ? '0 : exp_addr_q;
      if (accept) begin
        err_q       <= 16'h0;
        first_err_q <= '0;
        timeout_q   <= 1'b0;
      end else begin
        if (miss_q && (err_q != 16'hffff)) err_q <= err_q + 1'b1;
        if (miss_q && (err_q == 16'h0)) first_err_q <= miss_addr_q;
        if (to_hit) timeout_q <= 1'b1;
      end
      if (state_q == StEnd) pass_q <= pass_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_qdr_traffic_checker.sv
// Table-driven bench for qdr_traffic_checker with a small in-order memory responder.
module tb_qdr_traffic_checker;

  logic         clk = 1'b0;
  logic         rst, start, loop_en, stop, rd_valid;
  logic [1:0]   mode;
  logic [17:0]  base_addr, count;
  logic [31:0]  seed;
  logic [143:0] rd_data;
  logic         wr_en, rd_en, busy, done, timeout;
  logic [17:0]  wr_addr, rd_addr, first_err_addr;
  logic [143:0] wr_data;
  logic [15:0]  err_count, pass_count;

  qdr_traffic_checker dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .count(count), .seed(seed), .loop_en(loop_en), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .err_count(err_count), .first_err_addr(first_err_addr),
    .timeout(timeout), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder: stores writes, returns reads in order two cycles later.
  typedef struct { int due; logic [17:0] addr; } rq_t;
  rq_t          rq[$];
  logic [143:0] mem[logic [17:0]];
  int           cyc = 0, ret_idx = 0, wr_idx = 0, rd_idx = 0, done_cnt = 0;
  int           flip = -1;
  bit           hold_rd = 0, flush_req = 0, spur_req = 0;
  logic [17:0]  wa[8], ra[8];
  logic [143:0] w0, w1;

  initial begin : responder
    rq_t          e;
    logic [143:0] d;
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (start && !busy) begin
        ret_idx = 0; wr_idx = 0; rd_idx = 0;
      end
      if (wr_en) begin
        mem[wr_addr] = wr_data;
        if (wr_idx < 8) wa[wr_idx] = wr_addr;
        if (wr_idx == 0) w0 = wr_data;
        if (wr_idx == 1) w1 = wr_data;
        wr_idx++;
      end
      if (rd_en) begin
        if (rd_idx < 8) ra[rd_idx] = rd_addr;
        rd_idx++;
        rq.push_back('{cyc + 2, rd_addr});
      end
      if (flush_req) rq.delete();
      if (spur_req) rq.push_front('{cyc, 18'h0});
      rd_valid = 1'b0;
      rd_data  = '0;
      if (!hold_rd && rq.size() > 0 && rq[0].due <= cyc) begin
        e = rq.pop_front();
        d = mem.exists(e.addr) ? mem[e.addr] : '0;
        if (ret_idx == flip) d[0] = ~d[0];
        ret_idx++;
        rd_valid = 1'b1;
        rd_data  = d;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input logic [1:0] m, input logic [17:0] b, input logic [17:0] c,
                    input logic [31:0] s);
    mode = m; base_addr = b; count = c; seed = s;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic run_wait(input int max, output bit got, output int n);
    got = 0;
    n   = 0;
    while (!got && n < max) begin
      tick(1);
      n++;
      if (done) got = 1;
    end
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [17:0]  base;
    logic [17:0]  cnt;
    logic [31:0]  seed;
    int           flip;
    logic [15:0]  exp_err;
    logic [17:0]  exp_first;
    logic [143:0] exp_w0;
    bit           chk_w1;
    logic [143:0] exp_w1;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    bit got;
    int n, exp_pass, dc0;
    exp_pass = 0;
    rst = 1'b1; start = 1'b0; loop_en = 1'b0; stop = 1'b0;
    mode = 2'd0; base_addr = '0; count = '0; seed = '0;
    tick(3);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_wr_data", wr_data, '0);
    check("rst_err", err_count, 16'h0);
    check("rst_pass", pass_count, 16'h0);
    check("rst_timeout", timeout, 1'b0);
    rst = 1'b0;
    tick(1);

    vecs[0] = '{2'd0, 18'h0beef, 18'd1, 32'h0, -1, 16'd0, 18'h0,
                {36'h2fbbf, 36'h2fbbe, 36'h2fbbd, 36'h2fbbc}, 1'b0, 144'h0};
    vecs[1] = '{2'd1, 18'h00000, 18'd64, 32'h0, -1, 16'd0, 18'h0,
                144'h1_00000001_00000001_00000001_00000001, 1'b1,
                144'h0003_80200003_80200003_80200003_80200003};
    vecs[2] = '{2'd2, 18'h3fffe, 18'd4, 32'h0, -1, 16'd0, 18'h0, 144'h1, 1'b1, 144'h2};
    vecs[3] = '{2'd0, 18'h00100, 18'd8, 32'h0, 2, 16'd1, 18'h00102,
                {36'h403, 36'h402, 36'h401, 36'h400}, 1'b1,
                {36'h407, 36'h406, 36'h405, 36'h404}};
    vecs[4] = '{2'd3, 18'h00123, 18'd20, 32'h0, -1, 16'd0, 18'h0,
                {36'hffffffb70, 36'hffffffb71, 36'hffffffb72, 36'hffffffb73}, 1'b1,
                {36'hffffffb6c, 36'hffffffb6d, 36'hffffffb6e, 36'hffffffb6f}};
    vecs[5] = '{2'd1, 18'h00200, 18'd16, 32'hdeadbeef, 0, 16'd1, 18'h00200,
                144'hbeef_deadbeef_deadbeef_deadbeef_deadbeef, 1'b1,
                144'hdf74_ef76df74_ef76df74_ef76df74_ef76df74};

    foreach (vecs[i]) begin
      flip = vecs[i].flip;
      go(vecs[i].mode, vecs[i].base, vecs[i].cnt, vecs[i].seed);
      check($sformatf("v%0d_busy_run", i), busy, 1'b1);
      run_wait(400, got, n);
      check($sformatf("v%0d_done", i), got, 1'b1);
      tick(1);
      exp_pass++;
      check($sformatf("v%0d_busy_end", i), busy, 1'b0);
      check($sformatf("v%0d_err", i), err_count, vecs[i].exp_err);
      check($sformatf("v%0d_first", i), first_err_addr, vecs[i].exp_first);
      check($sformatf("v%0d_timeout", i), timeout, 1'b0);
      check($sformatf("v%0d_pass", i), pass_count, 16'(exp_pass));
      check($sformatf("v%0d_wa0", i), wa[0], vecs[i].base);
      check($sformatf("v%0d_w0", i), w0, vecs[i].exp_w0);
      if (vecs[i].chk_w1) check($sformatf("v%0d_w1", i), w1, vecs[i].exp_w1);
      if (i == 2) begin
        check("wrap_ra0", ra[0], 18'h3fffe);
        check("wrap_ra1", ra[1], 18'h3ffff);
        check("wrap_ra2", ra[2], 18'h00000);
        check("wrap_ra3", ra[3], 18'h00001);
        check("wrap_wa3", wa[3], 18'h00001);
      end
    end
    flip = -1;

    // Reads never return: issue stalls at the outstanding limit, then times out.
    hold_rd = 1;
    go(2'd0, 18'h00500, 18'd40, 32'h0);
    run_wait(1300, got, n);
    check("to_done", got, 1'b1);
    check("to_latency_window", (n >= 1024 && n <= 1100), 1'b1);
    tick(1);
    check("to_flag", timeout, 1'b1);
    check("to_busy", busy, 1'b0);
    check("to_rd_issued", 32'(rd_idx), 32'd16);
    check("to_pass_kept", pass_count, 16'(exp_pass));
    flush_req = 1;
    tick(2);
    flush_req = 0;
    hold_rd   = 0;
    tick(2);

    // Looping run, stopped during pass 3; a start while busy must be ignored.
    dc0 = done_cnt;
    loop_en = 1'b1;
    go(2'd0, 18'h00040, 18'd8, 32'h0);
    n = 0;
    while (pass_count != 16'(exp_pass + 1) && n < 200) begin tick(1); n++; end
    check("loop_pass1", pass_count, 16'(exp_pass + 1));
    check("loop_to_cleared", timeout, 1'b0);
    tick(3);
    go(2'd3, 18'h03000, 18'd2, 32'h0);
    check("loop_busy_after_start", busy, 1'b1);
    n = 0;
    while (pass_count != 16'(exp_pass + 2) && n < 200) begin tick(1); n++; end
    check("loop_pass2", pass_count, 16'(exp_pass + 2));
    tick(5);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    run_wait(200, got, n);
    check("loop_done", got, 1'b1);
    tick(1);
    exp_pass += 3;
    loop_en = 1'b0;
    check("loop_pass3", pass_count, 16'(exp_pass));
    check("loop_busy_end", busy, 1'b0);
    check("loop_err", err_count, 16'h0);
    check("loop_done_pulses", 32'(done_cnt - dc0), 32'd1);

    // Return with nothing outstanding counts as one error at address 0.
    spur_req = 1;
    tick(1);
    spur_req = 0;
    tick(4);
    check("spur_err", err_count, 16'h1);
    check("spur_first", first_err_addr, 18'h0);
    check("spur_pass_kept", pass_count, 16'(exp_pass));

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst2_err", err_count, 16'h0);
    check("rst2_pass", pass_count, 16'h0);
    check("rst2_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
